// File: rtl/ip4_mp_bk.sv
// ip4_mp_bk: NCH-channel round-robin shared memory bank, byte-enable writes, RDLAT 1|2.
// Define IP4_BK_PAR_EN to store and check one even-parity bit per byte lane.
module ip4_mp_bk #(
    parameter int NCH   = 2,
    parameter int DW    = 32,
    parameter int AW    = 8,
    parameter int RDLAT = 1,
    parameter int BW    = DW / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req,
    input  logic [NCH-1:0]           wen,
    input  logic [NCH-1:0][AW-1:0]   adr,
    input  logic [NCH-1:0][BW-1:0]   be,
    input  logic [NCH-1:0][DW-1:0]   datai,
    input  logic                     perr_inj,
    output logic [NCH-1:0]           ack,
    output logic [NCH-1:0]           vld,
    output logic [DW-1:0]            datao,
    output logic                     err
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PW-1:0]  ptr;
    logic [PW-1:0]  ptr_nxt;
    logic [NCH-1:0] gnt;
    logic           go;
    logic           sel_wen;
    logic [AW-1:0]  sel_adr;
    logic [BW-1:0]  sel_be;
    logic [DW-1:0]  sel_dat;
    logic           rd;

    // Pass 0 takes channels at or above ptr, pass 1 wraps to the rest.
    always_comb begin
        gnt     = '0;
        go      = 1'b0;
        sel_wen = 1'b0;
        sel_adr = '0;
        sel_be  = '0;
        sel_dat = '0;
        ptr_nxt = ptr;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < NCH; k++) begin
                if (!rst && !go && req[k] && (p == 1 || k >= int'(ptr))) begin
                    go      = 1'b1;
                    gnt[k]  = 1'b1;
                    sel_wen = wen[k];
                    sel_adr = adr[k];
                    sel_be  = be[k];
                    sel_dat = datai[k];
                    ptr_nxt = (k == NCH - 1) ? '0 : PW'(k + 1);
                end
            end
        end
    end

    assign ack = gnt;
    assign rd  = go & ~sel_wen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (go) begin
            ptr <= ptr_nxt;
        end
    end

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (go && sel_wen) begin
            for (int b = 0; b < BW; b++) begin
                if (sel_be[b]) begin
                    mem[sel_adr][8*b +: 8] <= sel_dat[8*b +: 8];
                end
            end
        end
    end

`ifdef IP4_BK_PAR_EN
    logic [BW-1:0] par [2**AW];
    logic [BW-1:0] p1;
    logic [BW-1:0] pn;

    function automatic logic [BW-1:0] lane_par(input logic [DW-1:0] d);
        logic [BW-1:0] r;
        r = '0;
        for (int b = 0; b < BW; b++) begin
            r[b] = ^d[8*b +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (go && sel_wen) begin
            for (int b = 0; b < BW; b++) begin
                if (sel_be[b]) begin
                    par[sel_adr][b] <= (^sel_dat[8*b +: 8]) ^ perr_inj;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1 <= '0;
        end else begin
            p1 <= rd ? par[sel_adr] : '0;
        end
    end
`endif

    // Array read at the ack edge; data is zeroed whenever no read returns.
    logic [NCH-1:0] v1;
    logic [DW-1:0]  d1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= '0;
            d1 <= '0;
        end else begin
            v1 <= rd ? gnt : '0;
            d1 <= rd ? mem[sel_adr] : '0;
        end
    end

    if (RDLAT == 2) begin : g_lat2
        logic [NCH-1:0] v2;
        logic [DW-1:0]  d2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v2 <= '0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                d2 <= d1;
            end
        end

        assign vld   = v2;
        assign datao = d2;
`ifdef IP4_BK_PAR_EN
        logic [BW-1:0] p2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                p2 <= '0;
            end else begin
                p2 <= p1;
            end
        end

        assign pn = p2;
`endif
    end else begin : g_lat1
        assign vld   = v1;
        assign datao = d1;
`ifdef IP4_BK_PAR_EN
        assign pn = p1;
`endif
    end

`ifdef IP4_BK_PAR_EN
    assign err = (|vld) && (lane_par(datao) != pn);
`else
    logic unused_perr;
    assign unused_perr = perr_inj;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ip4_mp_bk.sv
// Scoreboard bench for ip4_mp_bk: two 4-channel banks (RDLAT 1 and 2) share one stimulus
// stream; a reference model predicts grants and read returns.
module tb_ip4_mp_bk;

    logic             clk;
    logic             rst;
    logic [3:0]       req;
    logic [3:0]       wen;
    logic [3:0][7:0]  adr;
    logic [3:0][3:0]  be;
    logic [3:0][31:0] datai;
    logic             perr_inj;
    logic [3:0]       ack1, vld1, ack2, vld2;
    logic [31:0]      datao1, datao2;
    logic             err1, err2;

    ip4_mp_bk #(.NCH(4), .DW(32), .AW(8), .RDLAT(1)) u_l1 (
        .clk(clk), .rst(rst), .req(req), .wen(wen), .adr(adr), .be(be),
        .datai(datai), .perr_inj(perr_inj), .ack(ack1), .vld(vld1),
        .datao(datao1), .err(err1)
    );

    ip4_mp_bk #(.NCH(4), .DW(32), .AW(8), .RDLAT(2)) u_l2 (
        .clk(clk), .rst(rst), .req(req), .wen(wen), .adr(adr), .be(be),
        .datai(datai), .perr_inj(perr_inj), .ack(ack2), .vld(vld2),
        .datao(datao2), .err(err2)
    );

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] mm  [256];
    logic [3:0]  bad [256];
    int          mptr;
    int          cyc;
    int          n_vec;
    int          n_bad;
    logic [3:0]  last_ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Model of one cycle: round-robin winner, memory effect, read expectations.
    task automatic tick();
        int         w;
        int         a;
        logic [3:0] e;
        exp_t       x;
        @(negedge clk);
        w = -1;
        e = '0;
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && req[(mptr + k) % 4]) w = (mptr + k) % 4;
            end
        end
        if (w >= 0) e[w] = 1'b1;
        chk("ack_lat1", ack1, e);
        chk("ack_lat2", ack2, e);
        last_ack = e;
        if (w >= 0) begin
            a = int'(adr[w]);
            if (wen[w]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[w][b]) begin
                        mm[a][8*b +: 8] = datai[w][8*b +: 8];
                        bad[a][b] = perr_inj;
                    end
                end
            end else begin
                x.ch   = w;
                x.data = mm[a];
`ifdef IP4_BK_PAR_EN
                x.err  = |bad[a];
`else
                x.err  = 1'b0;
`endif
                x.due  = cyc + 1;
                q1.push_back(x);
                x.due  = cyc + 2;
                q2.push_back(x);
            end
            mptr = (w + 1) % 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mon(input int d, input logic [3:0] v, input logic [31:0] dq, input logic e);
        exp_t x;
        bit   have;
        if (rst) begin
            chk("rst_vld", v, 0);
            chk("rst_datao", dq, 0);
            chk("rst_err", e, 0);
            return;
        end
        have = (d == 0) ? (q1.size() > 0) : (q2.size() > 0);
        if (have) x = (d == 0) ? q1[0] : q2[0];
        if (v != 0) begin
            if (!have) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious_vld lat%0d: got vld %b expected none", d + 1, v);
            end else begin
                if (d == 0) void'(q1.pop_front());
                else void'(q2.pop_front());
                chk(d == 0 ? "vld_lat1" : "vld_lat2", v, 32'(1) << x.ch);
                chk(d == 0 ? "data_lat1" : "data_lat2", dq, x.data);
                chk(d == 0 ? "err_lat1" : "err_lat2", e, x.err);
                chk(d == 0 ? "due_lat1" : "due_lat2", cyc, x.due);
            end
        end else if (have && x.due <= cyc) begin
            if (d == 0) void'(q1.pop_front());
            else void'(q2.pop_front());
            n_vec++;
            n_bad++;
            $display("FAIL missing_vld lat%0d: got none expected ch%0d at cyc %0d",
                     d + 1, x.ch, x.due);
        end
    endtask

    always @(negedge clk) mon(0, vld1, datao1, err1);
    always @(negedge clk) mon(1, vld2, datao2, err2);

    task automatic do_req(input int ch, input bit w, input logic [7:0] a,
                          input logic [3:0] b, input logic [31:0] dt, input bit inj);
        bit got;
        req       = '0;
        req[ch]   = 1'b1;
        wen[ch]   = w;
        adr[ch]   = a;
        be[ch]    = b;
        datai[ch] = dt;
        perr_inj  = inj;
        got       = 1'b0;
        for (int t = 0; t < 16 && !got; t++) begin
            tick();
            got = last_ack[ch];
        end
        chk("req_acked", 32'(got), 1);
        req[ch]  = 1'b0;
        perr_inj = 1'b0;
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) tick();
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        mptr     = 0;
        rst      = 1'b1;
        req      = '1;
        wen      = '0;
        adr      = '0;
        be       = '0;
        datai    = '0;
        perr_inj = 1'b0;
        for (int i = 0; i < 256; i++) bad[i] = '0;
        repeat (3) tick();
        rst = 1'b0;
        req = '0;

        for (int i = 0; i < 256; i++) do_req(i % 4, 1'b1, 8'(i), 4'hF, $urandom, 1'b0);

        do_req(0, 1'b1, 8'h10, 4'hF, 32'hA5A5_1234, 1'b0);
        do_req(0, 1'b0, 8'h10, 4'h0, 32'h0, 1'b0);
        idle(3);

        do_req(1, 1'b1, 8'h03, 4'hF, 32'hFFFF_FFFF, 1'b0);
        do_req(1, 1'b1, 8'h03, 4'h5, 32'h0000_0000, 1'b0);
        do_req(1, 1'b0, 8'h03, 4'hF, 32'h0, 1'b0);
        do_req(2, 1'b1, 8'h07, 4'h0, 32'h1234_5678, 1'b0);
        do_req(2, 1'b0, 8'h07, 4'h0, 32'h0, 1'b0);

        do_req(0, 1'b0, 8'h00, 4'h0, 32'h0, 1'b0);
        do_req(0, 1'b0, 8'h01, 4'h0, 32'h0, 1'b0);
        do_req(0, 1'b0, 8'h02, 4'h0, 32'h0, 1'b0);
        idle(3);

        do_req(3, 1'b1, 8'h05, 4'h1, 32'h0000_00C3, 1'b1);
        do_req(3, 1'b0, 8'h05, 4'h0, 32'h0, 1'b0);
        do_req(3, 1'b1, 8'h05, 4'h1, 32'h0000_00C3, 1'b0);
        do_req(3, 1'b0, 8'h05, 4'h0, 32'h0, 1'b0);
        idle(3);

        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < 4; c++) begin
                if (req[c] && $urandom_range(19) == 0) begin
                    req[c] = 1'b0;
                end else if (!req[c] && $urandom_range(2) == 0) begin
                    req[c]   = 1'b1;
                    wen[c]   = 1'($urandom_range(1));
                    adr[c]   = 8'($urandom_range(255));
                    be[c]    = 4'($urandom_range(15));
                    datai[c] = $urandom;
                end
            end
            perr_inj = ($urandom_range(7) == 0);
            tick();
            req = req & ~last_ack;
        end
        perr_inj = 1'b0;
        idle(4);

        do_req(2, 1'b0, 8'h10, 4'h0, 32'h0, 1'b0);
        rst = 1'b1;
        q1.delete();
        q2.delete();
        mptr = 0;
        req  = '1;
        repeat (3) tick();
        req = '0;
        rst = 1'b0;

        wen = '0;
        for (int c = 0; c < 4; c++) adr[c] = 8'(c);
        adr[2] = 8'h10;
        req = '1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_order", last_ack, 32'(1) << (k % 4));
        end
        idle(6);

        chk("q_lat1_empty", q1.size(), 0);
        chk("q_lat2_empty", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ip4_mp_bk.md
# ip4_mp_bk

Parametrised multi-channel memory bank. It succeeds the fixed single-port shared-memory bank and the fixed two-port tag bank in the IP4 memory subsystem. NCH requestors share one storage array of 2^AW words through a round-robin arbiter, with a req/ack handshake, byte-enable writes and a configurable read latency. Shared-memory, tag and cache-data banks are all instances of this block.

## Interface
- NCH, 2, number of request channels (1..8)
- DW, 32, data width in bits; must be a multiple of 8
- AW, 8, address width; depth is 2^AW words
- RDLAT, 1, read latency in cycles after ack; legal values are 1 or 2
- BW, DW/8, byte lanes (derived; do not override)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req  in  NCH  per-channel request; held until ack
- wen  in  NCH  per-channel write (1) / read (0)
- adr  in  NCH x AW  per-channel word address
- be  in  NCH x BW  per-channel byte enables (writes only)
- datai  in  NCH x DW  per-channel write data
- perr_inj  in  1  test hook: invert stored parity on the granted write
- ack  out  NCH  one-hot grant; the request is accepted in this cycle
- vld  out  NCH  read data valid for the channel, one-hot
- datao  out  DW  shared read data, qualified by vld
- err  out  1  parity error on the read returned this cycle

## Operation
- Arbitration:
  - At most one access per cycle.
  - ack is combinational from req and the round-robin pointer ptr.
  - Grant goes to the first requesting channel at or after ptr, searching upward with wrap.
  - On any ack, ptr becomes the granted index + 1, modulo NCH.
  - With no requests, ptr holds.
- Handshake:
  - The requestor keeps req, wen, adr, be and datai stable until ack is seen.
  - Deasserting req before ack is legal and withdraws the request.
  - Back-to-back requests from one channel are legal; the channel is re-granted only when it wins the round-robin.
- Write:
  - On the clock edge of ack, each byte lane with be set is written.
  - Lanes with be clear keep their old value.
  - be = 0 is still acked and changes no data.
- Read:
  - The array is read at the ack edge.
  - datao and vld[i] are presented RDLAT cycles after ack and last one cycle.
  - be is ignored on reads.
  - Reads are pipelined, so one read result can return every cycle.
- Ordering: a read acked the cycle after a write to the same address returns the new data.
- Reset:
  - While rst is high: ack = 0, vld = 0, datao = 0, err = 0, ptr = 0.
  - Reads in flight when rst rises are dropped and never produce vld.
  - Array contents are not reset.
- NCH = 1: the arbiter reduces to ack = req, and ptr stays at 0.

## Timing
- Cycle 0: req[i] high and channel i wins, so ack[i] is high in the same cycle.
- Write: data is visible to any read acked from cycle 1 onward.
- Read, RDLAT = 1: vld[i]/datao registered at the end of cycle 0, visible in cycle 1.
- Read, RDLAT = 2: one extra output register stage, visible in cycle 2.
- The read pipeline fills and drains at one access per cycle; there is no backpressure on vld.

## Configuration
- IP4_BK_PAR_EN defined:
  - The array stores BW extra bits, one even-parity bit per byte lane, written with each enabled lane.
  - On read, parity is recomputed per lane.
  - err is asserted with vld, in the same cycle, if any lane mismatches.
  - perr_inj = 1 on a granted write stores inverted parity for the enabled lanes.
- IP4_BK_PAR_EN undefined:
  - No parity storage.
  - err is tied 0 and perr_inj is ignored.
  - The ports remain in the interface.

## Test plan
- Write/read, NCH = 2, RDLAT = 1:
  - Stimulus: ch0 writes adr 0x10, datai 0xA5A5_1234, be 0xF; next cycle ch0 reads 0x10.
  - Response: ack[0] in both request cycles; vld[0] one cycle after the read ack with datao 0xA5A5_1234.
- Byte enables:
  - Stimulus: write 0xFFFF_FFFF to adr 3, then write 0x0000_0000 with be 0x5, then read adr 3.
  - Response: datao 0xFF00_FF00.
- Round-robin:
  - Stimulus: NCH = 4, all req held high for 8 cycles from reset.
  - Response: ack order ch0, 1, 2, 3, 0, 1, 2, 3; no channel granted twice in a row.
- Latency, RDLAT = 2:
  - Stimulus: reads to 0, 1, 2 on consecutive cycles.
  - Response: vld high exactly 2 cycles after each ack, with data in order and back-to-back.
- Reset mid-read:
  - Stimulus: ack a read, then assert rst in the next cycle, before vld would appear.
  - Response: no vld, outputs 0, ptr 0 after release; array data is retained.
- Parity (IP4_BK_PAR_EN):
  - Stimulus: write adr 5 with perr_inj = 1, be 0x1, then read adr 5.
  - Response: err = 1 with vld.
  - Stimulus: rewrite with perr_inj = 0, then read.
  - Response: err = 0.
